// File: rtl/wb_commit_queue_if.sv
// Writeback commit queue bus: ALU/load result inputs, register-file write port, status.
// Forwarding lookup signals exist only when WB_FWD_EN is defined.
interface wb_commit_queue_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
);
   localparam int PW = $clog2(DEPTH) + 1;

   logic             alu_valid;
   logic [4:0]       alu_rd;
   logic [WIDTH-1:0] alu_data;
   logic             alu_ready;
   logic             mem_valid;
   logic [4:0]       mem_rd;
   logic [WIDTH-1:0] mem_data;
   logic             mem_ready;
   logic [4:0]       rf_rd_addr;
   logic [WIDTH-1:0] rf_write_data;
   logic             rf_reg_write;
   logic [PW-1:0]    pending;
   logic             idle;
`ifdef WB_FWD_EN
   logic [4:0]       fwd_rs1_addr;
   logic [4:0]       fwd_rs2_addr;
   logic             fwd_rs1_hit;
   logic             fwd_rs2_hit;
   logic [WIDTH-1:0] fwd_rs1_data;
   logic [WIDTH-1:0] fwd_rs2_data;
`endif

   modport slave (
      input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
`ifdef WB_FWD_EN
      input  fwd_rs1_addr, fwd_rs2_addr,
      output fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data,
`endif
      output alu_ready, mem_ready, rf_rd_addr, rf_write_data, rf_reg_write, pending, idle
   );

   modport master (
      output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
`ifdef WB_FWD_EN
      output fwd_rs1_addr, fwd_rs2_addr,
      input  fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data,
`endif
      input  alu_ready, mem_ready, rf_rd_addr, rf_write_data, rf_reg_write, pending, idle
   );
endinterface

// File: rtl/wb_commit_queue.sv
// In-order writeback FIFO retiring one register-file write per cycle; load results beat ALU results.
// Optional youngest-match forwarding lookup is enabled by defining WB_FWD_EN.
module wb_commit_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input logic           clk,
   input logic           rst_n,
   wb_commit_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   // Handshake: a result is taken on a rising edge where valid && ready.
   logic [4:0]       r_q_rd   [DEPTH];
   logic [WIDTH-1:0] r_q_data [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [PW-1:0]    r_count;
   logic             r_rf_we;
   logic [4:0]       r_rf_rd;
   logic [WIDTH-1:0] r_rf_data;

   logic             w_full;
   logic             w_mem_ready;
   logic             w_alu_ready;
   logic             w_mem_acc;
   logic             w_alu_acc;
   logic             w_push;
   logic             w_pop;
   logic [4:0]       w_push_rd;
   logic [WIDTH-1:0] w_push_data;

   // Ready is gated by reset so nothing is consumed while the queue is being cleared.
   assign w_full      = (r_count == PW'(DEPTH));
   assign w_mem_ready = rst_n && !w_full;
   assign w_alu_ready = rst_n && !w_full && !bus.mem_valid;
   assign w_mem_acc   = bus.mem_valid && w_mem_ready;
   assign w_alu_acc   = bus.alu_valid && w_alu_ready;
   assign w_push_rd   = w_mem_acc ? bus.mem_rd : bus.alu_rd;
   assign w_push_data = w_mem_acc ? bus.mem_data : bus.alu_data;
   assign w_push      = (w_mem_acc || w_alu_acc) && (w_push_rd != 5'd0);
   assign w_pop       = (r_count != '0);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_rd[r_wr_ptr]   <= w_push_rd;
         r_q_data[r_wr_ptr] <= w_push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_rf_we   <= 1'b0;
         r_rf_rd   <= 5'd0;
         r_rf_data <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + AW'(1);
            r_rf_rd   <= r_q_rd[r_rd_ptr];
            r_rf_data <= r_q_data[r_rd_ptr];
         end
         r_rf_we <= w_pop;
         if (w_push && !w_pop)      r_count <= r_count + PW'(1);
         else if (!w_push && w_pop) r_count <= r_count - PW'(1);
      end
   end

   assign bus.mem_ready     = w_mem_ready;
   assign bus.alu_ready     = w_alu_ready;
   assign bus.rf_reg_write  = r_rf_we;
   assign bus.rf_rd_addr    = r_rf_rd;
   assign bus.rf_write_data = r_rf_data;
   assign bus.pending       = r_count;
   assign bus.idle          = (r_count == '0) && !r_rf_we;

`ifdef WB_FWD_EN
   logic [AW-1:0] w_idx;

   // Walk oldest to newest after the output register so the youngest match overrides.
   always_comb begin
      w_idx            = '0;
      bus.fwd_rs1_hit  = 1'b0;
      bus.fwd_rs1_data = '0;
      bus.fwd_rs2_hit  = 1'b0;
      bus.fwd_rs2_data = '0;
      if (r_rf_we && (r_rf_rd == bus.fwd_rs1_addr) && (bus.fwd_rs1_addr != 5'd0)) begin
         bus.fwd_rs1_hit  = 1'b1;
         bus.fwd_rs1_data = r_rf_data;
      end
      if (r_rf_we && (r_rf_rd == bus.fwd_rs2_addr) && (bus.fwd_rs2_addr != 5'd0)) begin
         bus.fwd_rs2_hit  = 1'b1;
         bus.fwd_rs2_data = r_rf_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_rd_ptr + AW'(k);
         if (PW'(k) < r_count) begin
            if ((r_q_rd[w_idx] == bus.fwd_rs1_addr) && (bus.fwd_rs1_addr != 5'd0)) begin
               bus.fwd_rs1_hit  = 1'b1;
               bus.fwd_rs1_data = r_q_data[w_idx];
            end
            if ((r_q_rd[w_idx] == bus.fwd_rs2_addr) && (bus.fwd_rs2_addr != 5'd0)) begin
               bus.fwd_rs2_hit  = 1'b1;
               bus.fwd_rs2_data = r_q_data[w_idx];
            end
         end
      end
   end
`endif
endmodule
